// File: rtl/sipo_8bit.sv
// sipo_8bit: serial-in parallel-out deserializer for the 8-bit serial link.
// The transmitter sends bit 0 of each word first. This block rebuilds each
// word and offers it on a valid/ready port backed by a one-word holding
// register. A sticky flag reports any completed word that had to be dropped.
//
// Parameters:
//   WIDTH      bits per serial word (2..32)
//   MSB_FIRST  0: first received bit -> parallel_out[0]
//              1: first received bit -> parallel_out[WIDTH-1]
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   sipo_in      serial data bit
//   sipo_en      sipo_in carries a valid bit this cycle
//   frame_start  discard any partial word and restart the bit count
//   parallel_out assembled word (registered)
//   out_valid    parallel_out holds an undelivered word
//   out_ready    consumer accepts the word
//   bit_count    bits captured into the current partial word
//   overrun      sticky: a completed word was dropped
//   clr_overrun  clears overrun
//   state_dbg    receive FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word is transferred on every rising edge where
// out_valid && out_ready. out_valid never depends on out_ready in the same
// cycle; once raised, out_valid and parallel_out hold until that transfer.
module sipo_8bit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sipo_in,
  input  logic                         sipo_en,
  input  logic                         frame_start,
  output logic [WIDTH-1:0]             parallel_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         overrun,
  input  logic                         clr_overrun,
  output logic                         state_dbg
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  // Working values after an optional realign: frame_start throws away the
  // partial word before the bit of this cycle (if any) is considered.
  logic [WIDTH-1:0] base_sr;
  logic [CW-1:0]    base_count;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  always_comb begin
    base_sr    = frame_start ? '0 : sr_q;
    base_count = frame_start ? '0 : count_q;

    // LSB-first shifts right so the first bit drifts down to bit 0 after
    // WIDTH captures; MSB-first shifts left so it ends up at the top.
    if (MSB_FIRST) begin
      shifted = {base_sr[WIDTH-2:0], sipo_in};
    end else begin
      shifted = {sipo_in, base_sr[WIDTH-1:1]};
    end

    complete = sipo_en && (base_count == CW'(WIDTH-1));

    sr_d    = base_sr;
    count_d = base_count;
    par_d   = par_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (out_ready) begin
      valid_d = 1'b0;
    end
    if (clr_overrun) begin
      ovr_d = 1'b0;
    end

    if (sipo_en) begin
      sr_d = shifted;
      if (complete) begin
        count_d = '0;
        // The holding register is free if empty or being drained this edge.
        if (!valid_q || out_ready) begin
          par_d   = shifted;
          valid_d = 1'b1;
        end else begin
          // Drop the new word; setting overrun beats a same-edge clear.
          ovr_d = 1'b1;
        end
      end else begin
        count_d = base_count + CW'(1);
      end
    end

    state_d = (count_d == '0) ? IDLE : SHIFT;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      count_q <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      count_q <= count_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = par_q;
  assign out_valid    = valid_q;
  assign bit_count    = count_q;
  assign overrun      = ovr_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sipo_8bit.sv
module tb_sipo_8bit;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  logic sipo_in;
  logic sipo_en;
  logic frame_start;
  logic out_ready;
  logic clr_overrun;

  logic [7:0] par0, par1;
  logic       valid0, valid1;
  logic [3:0] cnt0, cnt1;
  logic       ovr0, ovr1;
  logic       st0, st1;

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sipo_8bit #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .sipo_in(sipo_in), .sipo_en(sipo_en),
    .frame_start(frame_start), .parallel_out(par0), .out_valid(valid0),
    .out_ready(out_ready), .bit_count(cnt0), .overrun(ovr0),
    .clr_overrun(clr_overrun), .state_dbg(st0)
  );

  sipo_8bit #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .sipo_in(sipo_in), .sipo_en(sipo_en),
    .frame_start(frame_start), .parallel_out(par1), .out_valid(valid1),
    .out_ready(out_ready), .bit_count(cnt1), .overrun(ovr1),
    .clr_overrun(clr_overrun), .state_dbg(st1)
  );

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are observed at
  // the same point, i.e. they show the result of the edge just taken.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    sipo_in     = b;
    sipo_en     = 1'b1;
    frame_start = fs;
    tick();
    sipo_en     = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (par0 !== 8'h00) begin errors++; $display("FAIL reset_par got %h exp 00", par0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid0); end
    checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", ovr0); end
    checks++; if (st0 !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", st0); end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'h5C;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b0);
      if (i < 7) begin
        checks++; if (cnt0 !== 4'(i + 1)) begin errors++; $display("FAIL basic_cnt bit %0d got %0d exp %0d", i, cnt0, i + 1); end
        checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL basic_state bit %0d got %b exp 1", i, st0); end
      end
    end
    checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL basic_cnt_wrap got %0d exp 0", cnt0); end
    checks++; if (st0 !== 1'b0) begin errors++; $display("FAIL basic_state_idle got %b exp 0", st0); end
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", valid0); end
    checks++; if (par0 !== 8'h5C) begin errors++; $display("FAIL basic_par got %h exp 5c", par0); end
    tick();
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL basic_valid_clr got %b exp 0", valid0); end
    checks++; if (par0 !== 8'h5C) begin errors++; $display("FAIL basic_par_hold got %h exp 5c", par0); end
  endtask

  task automatic test_gapped_order();
    logic [7:0] w;
    w = 8'hCC;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b0);
      if (i < 7) begin
        tick(); tick(); tick();
        checks++; if (cnt0 !== 4'(i + 1)) begin errors++; $display("FAIL gap_cnt bit %0d got %0d exp %0d", i, cnt0, i + 1); end
      end
    end
    checks++; if (par0 !== 8'hCC || valid0 !== 1'b1) begin errors++; $display("FAIL gap_lsb got %h/%b exp cc/1", par0, valid0); end
    // MSB-first instance reverses the arrival order: 0,0,1,1,0,0,1,1 -> 33.
    checks++; if (par1 !== 8'h33 || valid1 !== 1'b1) begin errors++; $display("FAIL gap_msb got %h/%b exp 33/1", par1, valid1); end
    tick();
    send_word(8'h5C);
    checks++; if (par1 !== 8'h3A || valid1 !== 1'b1) begin errors++; $display("FAIL order_msb got %h/%b exp 3a/1", par1, valid1); end
    checks++; if (par0 !== 8'h5C) begin errors++; $display("FAIL order_lsb got %h exp 5c", par0); end
    tick();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_word(8'h5C);
    checks++; if (par0 !== 8'h5C || valid0 !== 1'b1 || ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_first got %h/%b/%b exp 5c/1/0", par0, valid0, ovr0); end
    send_word(8'h00);
    checks++; if (par0 !== 8'h5C) begin errors++; $display("FAIL ovr_par got %h exp 5c", par0); end
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", valid0); end
    checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", ovr0); end
    checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL ovr_cnt got %0d exp 0", cnt0); end
    tick();
    checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ovr0); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", ovr0); end
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL ovr_clear_valid got %b exp 1", valid0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (valid0 !== 1'b0 || par0 !== 8'h5C) begin errors++; $display("FAIL ovr_drain got %b/%h exp 0/5c", valid0, par0); end
  endtask

  task automatic test_set_beats_clear();
    logic [7:0] w;
    w = 8'hA5;
    out_ready = 1'b0;
    send_word(8'h11);
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
    clr_overrun = 1'b1;
    send_bit(w[7], 1'b0);
    clr_overrun = 1'b0;
    checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL set_vs_clr got %b exp 1", ovr0); end
    checks++; if (par0 !== 8'h11) begin errors++; $display("FAIL set_vs_clr_par got %h exp 11", par0); end
    clr_overrun = 1'b1;
    out_ready   = 1'b1;
    tick();
    clr_overrun = 1'b0;
    out_ready   = 1'b0;
    checks++; if (ovr0 !== 1'b0 || valid0 !== 1'b0) begin errors++; $display("FAIL set_vs_clr_cleanup got %b/%b exp 0/0", ovr0, valid0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'hCC;
    out_ready = 1'b0;
    send_word(8'h5C);
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
    checks++; if (par0 !== 8'h5C || valid0 !== 1'b1) begin errors++; $display("FAIL b2b_hold got %h/%b exp 5c/1", par0, valid0); end
    out_ready = 1'b1;
    send_bit(w[7], 1'b0);
    checks++; if (par0 !== 8'hCC) begin errors++; $display("FAIL b2b_par got %h exp cc", par0); end
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", valid0); end
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b exp 0", ovr0); end
    tick();
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", valid0); end
  endtask

  task automatic test_realign();
    logic [7:0] w;
    w = 8'hCC;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    checks++; if (cnt0 !== 4'd5) begin errors++; $display("FAIL realign_garbage_cnt got %0d exp 5", cnt0); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL realign_idle_cnt got %0d exp 0", cnt0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL realign_idle_valid got %b exp 0", valid0); end
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    send_bit(w[0], 1'b1);
    checks++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL realign_cnt got %0d exp 1", cnt0); end
    for (int i = 1; i < 8; i++) send_bit(w[i], 1'b0);
    checks++; if (par0 !== 8'hCC || valid0 !== 1'b1) begin errors++; $display("FAIL realign_word got %h/%b exp cc/1", par0, valid0); end
    tick();
    checks++; if (valid0 !== 1'b0 || cnt0 !== 4'd0) begin errors++; $display("FAIL realign_after got %b/%0d exp 0/0", valid0, cnt0); end
  endtask

  task automatic test_reset_mid();
    int deliveries;
    logic [7:0] w;
    w = 8'hCC;
    out_ready = 1'b0;
    send_word(8'h5C);
    send_word(8'h00);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    checks++; if (valid0 !== 1'b1 || ovr0 !== 1'b1 || cnt0 !== 4'd4) begin errors++; $display("FAIL rmid_setup got %b/%b/%0d exp 1/1/4", valid0, ovr0, cnt0); end
    reset     = 1'b0;
    sipo_en   = 1'b1;
    sipo_in   = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b1;
    sipo_en   = 1'b0;
    out_ready = 1'b0;
    checks++; if (par0 !== 8'h00 || valid0 !== 1'b0 || ovr0 !== 1'b0 || cnt0 !== 4'd0 || st0 !== 1'b0) begin
      errors++; $display("FAIL rmid_reset got %h/%b/%b/%0d/%b exp 00/0/0/0/0", par0, valid0, ovr0, cnt0, st0);
    end
    out_ready  = 1'b1;
    deliveries = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b0);
      if (valid0 === 1'b1) deliveries++;
    end
    checks++; if (par0 !== 8'hCC) begin errors++; $display("FAIL rmid_word got %h exp cc", par0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid0 === 1'b1) deliveries++;
    end
    checks++; if (deliveries !== 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", deliveries); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset       = 1'b0;
    sipo_in     = 1'b0;
    sipo_en     = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_gapped_order();
    test_overrun();
    test_set_beats_clear();
    test_back_to_back();
    test_realign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
